// File: rtl/stage_five_writeback_if.sv
// Upstream-facing bundle for the writeback stage: the instruction leaving the
// memory-access stage, the data-memory response, and the load-not-ready stall.
interface stage_five_writeback_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RA_W   = 5
);
   logic              in_valid;
   logic              in_reg_write;
   logic              in_mem_to_reg;
   logic [RA_W-1:0]   in_rd;
   logic [DATA_W-1:0] in_alu_result;
   logic              mem_rdy;
   logic [DATA_W-1:0] mem_data;
   logic              stall_o;

   // Upstream pipeline / memory side
   modport master (
      output in_valid, in_reg_write, in_mem_to_reg, in_rd, in_alu_result, mem_rdy, mem_data,
      input  stall_o
   );

   // Writeback stage side
   modport slave (
      input  in_valid, in_reg_write, in_mem_to_reg, in_rd, in_alu_result, mem_rdy, mem_data,
      output stall_o
   );
endinterface

// File: rtl/stage_five_writeback.sv
// Writeback stage: re-aligns control and ALU result with load data that arrives
// one cycle after the access, drives the register-file write port, and keeps
// forwarding info, performance counters and a sticky stall-timeout flag.
module stage_five_writeback #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned RA_W      = 5,
   parameter int unsigned STALL_MAX = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   stage_five_writeback_if.slave bus,
   output logic                 rf_we,
   output logic [RA_W-1:0]      rf_waddr,
   output logic [DATA_W-1:0]    rf_wdata,
   output logic                 fwd_valid,
   output logic [RA_W-1:0]      fwd_rd,
   output logic [31:0]          retired,
   output logic [31:0]          stall_cycles,
   output logic                 err_o
);

   localparam logic [7:0] StallMax = 8'(STALL_MAX);

   typedef enum logic {StBubble, StRun} slot_state_e;

   slot_state_e       state_q, state_d;
   logic              stall;
   logic              accept;
   logic              valid_a;
   logic              reg_write_a;
   logic              mem_to_reg_a;
   logic [RA_W-1:0]   rd_a;
   logic [DATA_W-1:0] alu_result_a;
   logic              we_a;
   logic [7:0]        stall_run;

   // A load whose memory is not ready cannot be accepted; upstream holds.
   assign stall           = bus.in_valid & bus.in_mem_to_reg & ~bus.mem_rdy;
   assign bus.stall_o     = stall;
   assign accept          = bus.in_valid & ~stall;

   assign valid_a   = (state_q == StRun);
   assign we_a      = valid_a & reg_write_a & (rd_a != '0);
   // Load data is not yet in the output register, so the hazard unit filters loads.
   assign fwd_valid = we_a;
   assign fwd_rd    = rd_a;

   // Slot A occupancy: every edge either takes the accepted instruction or a bubble.
   always_comb begin
      state_d = StBubble;
      if (accept) begin
         state_d = StRun;
      end
   end

   // Slot A state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StBubble;
      end else begin
         state_q <= state_d;
      end
   end

   // Slot A payload; held on bubbles since it is don't-care when invalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_a  <= 1'b0;
         mem_to_reg_a <= 1'b0;
         rd_a         <= '0;
         alu_result_a <= '0;
      end else if (accept) begin
         reg_write_a  <= bus.in_reg_write;
         mem_to_reg_a <= bus.in_mem_to_reg;
         rd_a         <= bus.in_rd;
         alu_result_a <= bus.in_alu_result;
      end
   end

   // Register-file write port; address/data hold when no write happens.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= we_a;
         if (we_a) begin
            rf_waddr <= rd_a;
            rf_wdata <= mem_to_reg_a ? bus.mem_data : alu_result_a;
         end
      end
   end

   // Free-running retire and stall counters, both wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired      <= '0;
         stall_cycles <= '0;
      end else begin
         if (valid_a) begin
            retired <= retired + 32'd1;
         end
         if (stall) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
      end
   end

   // Consecutive-stall run length and sticky timeout error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_run <= '0;
         err_o     <= 1'b0;
      end else if (stall) begin
         if (stall_run < StallMax) begin
            stall_run <= stall_run + 8'd1;
         end
         // Set on the edge where the run length reaches StallMax.
         if (stall_run >= StallMax - 8'd1) begin
            err_o <= 1'b1;
         end
      end else begin
         stall_run <= '0;
      end
   end

endmodule

// File: tb/tb_stage_five_writeback.sv
// Scoreboard bench for stage_five_writeback: expected writes are queued when an
// instruction is accepted and matched against rf_we pulses two cycles later.
module tb_stage_five_writeback;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned RA_W      = 5;
   localparam int unsigned STALL_MAX = 4;

   typedef struct {
      logic [RA_W-1:0]   addr;
      logic [DATA_W-1:0] data;
      int                due;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              rf_we;
   logic [RA_W-1:0]   rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              fwd_valid;
   logic [RA_W-1:0]   fwd_rd;
   logic [31:0]       retired;
   logic [31:0]       stall_cycles;
   logic              err_o;

   exp_t        sb[$];
   exp_t        e_mon;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   int          exp_retired = 0;
   int          exp_stalls = 0;

   stage_five_writeback_if #(.DATA_W(DATA_W), .RA_W(RA_W)) bus ();

   stage_five_writeback #(
      .DATA_W   (DATA_W),
      .RA_W     (RA_W),
      .STALL_MAX(STALL_MAX)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .fwd_valid   (fwd_valid),
      .fwd_rd      (fwd_rd),
      .retired     (retired),
      .stall_cycles(stall_cycles),
      .err_o       (err_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor: every rf_we pulse must match the oldest expected write on its due cycle.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (rf_we === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL sb_unexpected_write: got rf_we=1 waddr=%0d wdata=%h, required no write",
                        rf_waddr, rf_wdata);
            end else begin
               e_mon = sb.pop_front();
               if (rf_waddr !== e_mon.addr || rf_wdata !== e_mon.data || cyc != e_mon.due) begin
                  n_err++;
                  $display("FAIL sb_write: got waddr=%0d wdata=%h cyc=%0d, required waddr=%0d wdata=%h cyc=%0d",
                           rf_waddr, rf_wdata, cyc, e_mon.addr, e_mon.data, e_mon.due);
               end
            end
         end else if (sb.size() != 0 && cyc >= sb[0].due) begin
            n_cmp++;
            n_err++;
            e_mon = sb.pop_front();
            $display("FAIL sb_missing_write: got rf_we=%b at cyc=%0d, required write waddr=%0d wdata=%h",
                     rf_we, cyc, e_mon.addr, e_mon.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got simulation still running, required completion");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_valid      = 1'b0;
      bus.in_reg_write  = 1'b0;
      bus.in_mem_to_reg = 1'b0;
      bus.in_rd         = '0;
      bus.in_alu_result = '0;
      bus.mem_rdy       = 1'b1;
   endtask

   // Drives one non-stalling instruction for a cycle; mem_data follows in the next cycle.
   task automatic issue(input logic rw, input logic m2r, input logic [RA_W-1:0] rd,
                        input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] md);
      exp_t e;
      bus.in_valid      = 1'b1;
      bus.in_reg_write  = rw;
      bus.in_mem_to_reg = m2r;
      bus.in_rd         = rd;
      bus.in_alu_result = alu;
      bus.mem_rdy       = 1'b1;
      exp_retired++;
      if (rw && rd != 0) begin
         e.addr = rd;
         e.data = m2r ? md : alu;
         e.due  = cyc + 2;
         sb.push_back(e);
      end
      tick();
      bus.in_valid = 1'b0;
      bus.mem_data = md;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (sb.size() != 0 && budget < 10) begin
         tick();
         budget++;
      end
      tick();
      tick();
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending writes, required 0", sb.size());
         sb.delete();
      end
      n_cmp++;
      if (retired !== 32'(exp_retired)) begin
         n_err++;
         $display("FAIL retired: got %0d, required %0d", retired, exp_retired);
      end
      n_cmp++;
      if (stall_cycles !== 32'(exp_stalls)) begin
         n_err++;
         $display("FAIL stall_cycles: got %0d, required %0d", stall_cycles, exp_stalls);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      bus.mem_data = '0;
      #1;
      n_cmp++;
      if ({rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, retired, stall_cycles, err_o} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got we=%b wa=%0d wd=%h fv=%b frd=%0d ret=%0d stc=%0d err=%b, required all 0",
                  rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, retired, stall_cycles, err_o);
      end
      // stall_o is purely combinational, so it must respond even in reset
      bus.in_valid      = 1'b1;
      bus.in_mem_to_reg = 1'b1;
      bus.mem_rdy       = 1'b0;
      tick();
      n_cmp++;
      if (bus.stall_o !== 1'b1) begin
         n_err++;
         $display("FAIL reset_stall_comb: got stall_o=%b, required 1", bus.stall_o);
      end
      tick();
      idle_inputs();
      #1;
      n_cmp++;
      if (bus.stall_o !== 1'b0 || stall_cycles !== 32'd0) begin
         n_err++;
         $display("FAIL reset_idle: got stall_o=%b stall_cycles=%0d, required 0/0",
                  bus.stall_o, stall_cycles);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_alu();
      issue(1'b1, 1'b0, 5'd5, 32'h0000_1234, 32'hFFFF_0000);
      n_cmp++;
      if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5) begin
         n_err++;
         $display("FAIL alu_fwd: got fwd_valid=%b fwd_rd=%0d, required 1/5", fwd_valid, fwd_rd);
      end
      drain();
   endtask

   task automatic test_load();
      issue(1'b1, 1'b1, 5'd7, 32'h0000_0100, 32'hDEAD_BEEF);
      drain();
      n_cmp++;
      if (rf_waddr !== 5'd7 || rf_wdata !== 32'hDEAD_BEEF) begin
         n_err++;
         $display("FAIL load_hold: got waddr=%0d wdata=%h, required 7/deadbeef", rf_waddr, rf_wdata);
      end
   endtask

   task automatic test_stall();
      exp_t e;
      bus.in_valid      = 1'b1;
      bus.in_reg_write  = 1'b1;
      bus.in_mem_to_reg = 1'b1;
      bus.in_rd         = 5'd9;
      bus.in_alu_result = 32'h0000_0200;
      bus.mem_rdy       = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (bus.stall_o !== 1'b1) begin
            n_err++;
            $display("FAIL stall_high[%0d]: got stall_o=%b, required 1", i, bus.stall_o);
         end
         exp_stalls++;
         tick();
      end
      bus.mem_rdy = 1'b1;
      #1;
      n_cmp++;
      if (bus.stall_o !== 1'b0) begin
         n_err++;
         $display("FAIL stall_release: got stall_o=%b, required 0", bus.stall_o);
      end
      exp_retired++;
      e.addr = 5'd9;
      e.data = 32'hCAFE_F00D;
      e.due  = cyc + 2;
      sb.push_back(e);
      tick();
      bus.in_valid = 1'b0;
      bus.mem_data = 32'hCAFE_F00D;
      drain();
   endtask

   task automatic test_suppress();
      issue(1'b1, 1'b0, 5'd0, 32'h0000_0055, 32'h1111_1111);
      n_cmp++;
      if (fwd_valid !== 1'b0) begin
         n_err++;
         $display("FAIL suppress_r0_fwd: got fwd_valid=%b, required 0", fwd_valid);
      end
      issue(1'b0, 1'b1, 5'd12, 32'h0000_0066, 32'h0000_0077);
      n_cmp++;
      if (fwd_valid !== 1'b0) begin
         n_err++;
         $display("FAIL suppress_store_fwd: got fwd_valid=%b, required 0", fwd_valid);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [RA_W-1:0]   rd;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] md;
      logic              rw;
      logic              m2r;
      issue(1'b1, 1'b0, 5'd3, 32'h0000_0011, 32'h0);
      issue(1'b1, 1'b0, 5'd3, 32'h0000_0022, 32'h0);
      issue(1'b1, 1'b1, 5'd4, 32'h0000_0033, 32'hA5A5_5A5A);
      issue(1'b1, 1'b0, 5'd31, 32'h8000_0001, 32'h0);
      drain();
      n_cmp++;
      if (rf_waddr !== 5'd31 || rf_wdata !== 32'h8000_0001) begin
         n_err++;
         $display("FAIL b2b_last_wins: got waddr=%0d wdata=%h, required 31/80000001",
                  rf_waddr, rf_wdata);
      end
      for (int i = 0; i < 16; i++) begin
         rw  = 1'($urandom_range(0, 3) != 0);
         m2r = 1'($urandom_range(0, 1));
         rd  = RA_W'($urandom_range(0, 31));
         alu = $urandom();
         md  = $urandom();
         issue(rw, m2r, rd, alu, md);
      end
      drain();
   endtask

   task automatic test_reset_midstream();
      issue(1'b1, 1'b0, 5'd6, 32'h0000_0AAA, 32'h0);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, retired, stall_cycles} !== '0) begin
         n_err++;
         $display("FAIL midreset_outputs: got we=%b wa=%0d wd=%h fv=%b frd=%0d ret=%0d stc=%0d, required all 0",
                  rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, retired, stall_cycles);
      end
      sb.delete();
      exp_retired = 0;
      exp_stalls  = 0;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      issue(1'b1, 1'b0, 5'd8, 32'h0000_0BBB, 32'h0);
      drain();
   endtask

   task automatic test_timeout();
      exp_t e;
      bus.in_valid      = 1'b1;
      bus.in_reg_write  = 1'b1;
      bus.in_mem_to_reg = 1'b1;
      bus.in_rd         = 5'd10;
      bus.in_alu_result = 32'h0000_0300;
      bus.mem_rdy       = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         exp_stalls++;
         tick();
         n_cmp++;
         if (err_o !== 1'(i >= 4)) begin
            n_err++;
            $display("FAIL timeout_edge[%0d]: got err_o=%b, required %b", i, err_o, 1'(i >= 4));
         end
      end
      bus.mem_rdy = 1'b1;
      exp_retired++;
      e.addr = 5'd10;
      e.data = 32'h1357_9BDF;
      e.due  = cyc + 2;
      sb.push_back(e);
      tick();
      bus.in_valid = 1'b0;
      bus.mem_data = 32'h1357_9BDF;
      drain();
      n_cmp++;
      if (err_o !== 1'b1) begin
         n_err++;
         $display("FAIL timeout_sticky: got err_o=%b, required 1", err_o);
      end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (err_o !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_clear: got err_o=%b, required 0", err_o);
      end
      tick();
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_stall();
      test_suppress();
      test_back_to_back();
      test_reset_midstream();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/stage_five_writeback.md
# stage_five_writeback

Writeback stage of the MUSA five-stage core. It sits directly downstream of the memory-access stage (data memory plus output register). It re-aligns the instruction's control and ALU result with the registered load data, which arrives one cycle after the access. It then selects the writeback value and drives the register-file write port, while also providing forwarding data, a load-not-ready stall, retire/stall performance counters and a sticky stall-timeout error.

## Interface
- DATA_W, 32, datapath width (matches memory data_out)
- RA_W, 5, register address width
- STALL_MAX, 255, consecutive stall cycles before err_o sets (1..255)
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset; **asynchronous, active-high**
- in_valid  in  1  instruction present at memory access this cycle (cycle T)
- in_reg_write  in  1  instruction writes a register
- in_mem_to_reg  in  1  writeback value is load data (instruction is a load)
- in_rd  in  RA_W  destination register
- in_alu_result  in  DATA_W  ALU result / address carried from EX
- mem_rdy  in  1  data memory ready, sampled in cycle T
- mem_data  in  DATA_W  registered memory data_out, valid in cycle T+1
- stall_o  out  1  combinational: hold upstream stages this cycle
- rf_we  out  1  register-file write strobe
- rf_waddr  out  RA_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- fwd_valid  out  1  slot A holds a register-writing instruction
- fwd_rd  out  RA_W  slot A destination
- retired  out  32  retired instruction count
- stall_cycles  out  32  total cycles with stall_o high
- err_o  out  1  sticky stall timeout

## Operation
- stall_o = in_valid & in_mem_to_reg & ~mem_rdy. While stall_o is high, upstream holds all in_* stable.
- Slot A (registered, written every edge):
  - valid_a <= in_valid & ~stall_o
  - it captures reg_write, mem_to_reg, rd and alu_result when in_valid & ~stall_o
  - otherwise it takes a bubble (valid_a=0, other fields don't-care)
- Effective write: we_a = valid_a & reg_write_a & (rd_a != 0). Register 0 is never written.
- Output register (written every edge):
  - rf_we <= we_a
  - rf_waddr <= rd_a
  - rf_wdata <= mem_to_reg_a ? mem_data : alu_result_a
  - When we_a=0, waddr/wdata keep their previous values.
- fwd_valid = we_a, fwd_rd = rd_a. These are combinational from slot A. Load data is not forwardable from slot A; the hazard unit handles this.
- A store or other non-writing instruction (reg_write=0) passes through slot A and retires but produces no rf_we. mem_to_reg with reg_write=0 means mem_data is ignored.
- retired increments by 1 on each edge where valid_a=1 and wraps at 2^32.
- stall_cycles increments on each edge where stall_o=1 and wraps.
- Consecutive-stall counter (8-bit):
  - increments on each edge with stall_o=1 and clears on each edge with stall_o=0
  - saturates at STALL_MAX
  - on the edge it reaches STALL_MAX, err_o sets and stays set until rst
- State summary: valid_a is the only control state. RUN (valid_a=1) and BUBBLE (valid_a=0) are the two states, and transitions follow the slot A rule above.

## Timing
- Reset values, asserted asynchronously:
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - valid_a=0, fwd_valid=0, fwd_rd=0
  - retired=0, stall_cycles=0
  - consecutive counter=0, err_o=0
- stall_o depends only on inputs, so it is valid during reset.
- Latency: instruction accepted in cycle T -> slot A in T+1 (mem_data valid) -> rf_we high in T+2 for exactly one cycle per instruction.
- Throughput: one instruction per cycle with no stalls. Each stall cycle inserts one bubble, which gives rf_we=0 two cycles later.
- Back-to-back writes to the same rd produce two consecutive rf_we pulses. The later one wins.
- If rst asserts mid-operation, in-flight slot A and output-register contents are discarded with no partial write. The first possible rf_we is 2 cycles after the first accepted post-reset input.
- Stall released and a new input in the same cycle: the input is accepted when mem_rdy=1 in that cycle.

## Test plan
- Reset: assert rst mid-stream with slot A valid -> all outputs 0 immediately, no rf_we after release until two cycles after the next accepted input.
- ALU op: in_valid=1, reg_write=1, mem_to_reg=0, rd=5, alu=0x0000_1234 at T -> fwd_valid=1/fwd_rd=5 in T+1; rf_we=1, waddr=5, wdata=0x1234 in T+2; retired=1.
- Load with ready memory: mem_to_reg=1, rd=7, mem_rdy=1 at T, mem_data=0xDEAD_BEEF in T+1 -> rf_we=1, waddr=7, wdata=0xDEADBEEF in T+2.
- Load stall: mem_rdy=0 for 3 cycles then 1 -> stall_o high 3 cycles, stall_cycles=3, three bubbles (no rf_we), then a single write 2 cycles after acceptance.
- Suppression: rd=0 with reg_write=1, and a store with reg_write=0 -> no rf_we for either, retired increments by 2.
- Timeout: STALL_MAX=4, mem_rdy held 0 -> err_o sets on the 4th stall edge and remains 1 after the stall clears until rst.
